alu_issue_unit: RTL and testbench

Upstream and downstream neighbour of the 12-bit combinational ALU. It accepts 12-bit instructions over a valid/ready handshake and reads operands from a 4-entry x 12-bit register file. It drives the ALU operand and select lines for one cycle, captures the ALU result and writes it back to the register file. A 3-state FSM sequences each instruction; a single clock domain is used throughout.

---
 rtl/cpu_pkg.sv | 49 ++++
 rtl/reg_file_4x12.sv | 39 +++
 rtl/alu_issue_unit.sv | 125 ++++++++++++
 tb/tb_alu_issue_unit.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg: opcodes, FSM states and instruction fields for the ALU issue |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cpu_pkg;

  localparam int DATA_W = 12;
  localparam int NREGS  = 4;

  localparam int OP_MSB  = 11;
  localparam int OP_LSB  = 8;
  localparam int RD_MSB  = 7;
  localparam int RD_LSB  = 6;
  localparam int RS_MSB  = 5;
  localparam int RS_LSB  = 4;
  localparam int RT_MSB  = 3;
  localparam int RT_LSB  = 2;
  localparam int IMM_MSB = 5;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_LDI = 4'b0110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_NOT);
  endfunction

  function automatic logic op_writes(input logic [3:0] op);
    return is_alu_op(op) || (op == OP_LDI);
  endfunction

  function automatic logic op_illegal(input logic [3:0] op);
    return op > OP_LDI;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_4x12.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_file_4x12: sync-write register file, two read ports + debug read |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module reg_file_4x12
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [1:0]        i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [1:0]        i_raddr_a,
  input  logic [1:0]        i_raddr_b,
  input  logic [1:0]        i_dbg_addr,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b,
  output logic [DATA_W-1:0] o_dbg_data
);

  logic [DATA_W-1:0] r_regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a  = r_regs[i_raddr_a];
  assign o_rdata_b  = r_regs[i_raddr_b];
  assign o_dbg_data = r_regs[i_dbg_addr];

endmodule
`default_nettype wire

// File: rtl/alu_issue_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_issue_unit: 3-cycle issue/execute/writeback around external ALU  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_issue_unit
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  output logic              result_valid,
  output logic [DATA_W-1:0] result,
  output logic [1:0]        result_rd,
  output logic              illegal,
  input  logic [1:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_instr;
  logic [DATA_W-1:0] r_wb_data;
  logic [DATA_W-1:0] w_wb_data_nxt;
  logic [DATA_W-1:0] w_rs_data;
  logic [DATA_W-1:0] w_rt_data;
  logic [3:0]        w_op;
  logic [1:0]        w_rd;
  logic [1:0]        w_rs;
  logic [1:0]        w_rt;
  logic [5:0]        w_imm;
  logic              w_we;

  assign w_op  = r_instr[OP_MSB:OP_LSB];
  assign w_rd  = r_instr[RD_MSB:RD_LSB];
  assign w_rs  = r_instr[RS_MSB:RS_LSB];
  assign w_rt  = r_instr[RT_MSB:RT_LSB];
  assign w_imm = r_instr[IMM_MSB:IMM_LSB];

  reg_file_4x12 u_rf (
    .clk        (clk),
    .rst        (rst),
    .i_we       (w_we),
    .i_waddr    (w_rd),
    .i_wdata    (r_wb_data),
    .i_raddr_a  (w_rs),
    .i_raddr_b  (w_rt),
    .i_dbg_addr (dbg_addr),
    .o_rdata_a  (w_rs_data),
    .o_rdata_b  (w_rt_data),
    .o_dbg_data (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_instr   <= '0;
      r_wb_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && instr_valid) begin
        r_instr <= instr;
      end
      if (r_state == EXEC) begin
        r_wb_data <= w_wb_data_nxt;
      end
    end
  end

  // All handshake and ALU-facing outputs decode from the current state, so
  // reset alone returns them to their idle values.
  always_comb begin
    w_state_nxt   = r_state;
    w_wb_data_nxt = '0;
    w_we          = 1'b0;
    instr_ready   = 1'b0;
    alu_a         = '0;
    alu_b         = '0;
    alu_sel       = OP_NOP;
    result_valid  = 1'b0;
    result        = '0;
    result_rd     = '0;
    illegal       = 1'b0;
    case (r_state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        alu_a = w_rs_data;
        alu_b = w_rt_data;
        if (is_alu_op(w_op)) begin
          alu_sel       = w_op;
          w_wb_data_nxt = alu_out;
        end else if (w_op == OP_LDI) begin
          w_wb_data_nxt = {{(DATA_W-6){1'b0}}, w_imm};
        end
        w_state_nxt = WB;
      end
      WB: begin
        if (op_writes(w_op)) begin
          w_we         = 1'b1;
          result_valid = 1'b1;
          result       = r_wb_data;
          result_rd    = w_rd;
        end
        illegal     = op_illegal(w_op);
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_issue_unit: scoreboard bench for the issue unit + ALU model   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_alu_issue_unit;

  typedef struct {
    bit          ill;
    logic [1:0]  rd;
    logic [11:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [11:0] instr = '0;
  logic [11:0] alu_a;
  logic [11:0] alu_b;
  logic [3:0]  alu_sel;
  logic [11:0] alu_out;
  logic        result_valid;
  logic [11:0] result;
  logic [1:0]  result_rd;
  logic        illegal;
  logic [1:0]  dbg_addr = '0;
  logic [11:0] dbg_data;

  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;
  exp_t        sb_q[$];
  logic [11:0] mdl [4];

  alu_issue_unit dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_sel      (alu_sel),
    .alu_out      (alu_out),
    .result_valid (result_valid),
    .result       (result),
    .result_rd    (result_rd),
    .illegal      (illegal),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  always #5 clk = ~clk;

  // Combinational 12-bit ALU neighbour
  always_comb begin
    case (alu_sel)
      4'b0001: alu_out = alu_a + alu_b;
      4'b0010: alu_out = alu_a - alu_b;
      4'b0011: alu_out = alu_a & alu_b;
      4'b0100: alu_out = alu_a | alu_b;
      4'b0101: alu_out = ~alu_a;
      default: alu_out = 12'h000;
    endcase
  end

  function automatic logic [11:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [1:0] rt);
    return {op, rd, rs, rt, 2'b00};
  endfunction

  // Scoreboard consumer: every WB pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (result_valid || illegal)) begin
      exp_t e;
      pulses++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: valid=%0b illegal=%0b result=%h rd=%0d, required none",
                 result_valid, illegal, result, result_rd);
      end else begin
        e = sb_q.pop_front();
        if (e.ill) begin
          if (illegal !== 1'b1 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL illegal_pulse: illegal=%0b valid=%0b, required illegal=1 valid=0",
                     illegal, result_valid);
          end
        end else if (result_valid !== 1'b1 || illegal !== 1'b0 ||
                     result !== e.val || result_rd !== e.rd) begin
          errors++;
          $display("FAIL writeback: valid=%0b illegal=%0b result=%h rd=%0d, required valid=1 result=%h rd=%0d",
                   result_valid, illegal, result, result_rd, e.val, e.rd);
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (instr_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (instr_ready !== 1'b1) begin
      $display("FAIL ready_timeout: instr_ready=%0b, required 1", instr_ready);
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "ready timeout");
    end
  endtask

  // Issues one instruction, checks EXEC/WB handshake and ALU lines, and
  // pushes the expected writeback computed from the register model.
  task automatic issue(input logic [11:0] ins);
    logic [3:0]  op;
    logic [1:0]  rd, rs, rt;
    logic [11:0] a, b, v;
    bit          wr;
    exp_t        e;
    op = ins[11:8]; rd = ins[7:6]; rs = ins[5:4]; rt = ins[3:2];
    a = mdl[rs]; b = mdl[rt]; wr = 1'b1; v = 12'h000;
    case (op)
      4'b0001: v = a + b;
      4'b0010: v = a - b;
      4'b0011: v = a & b;
      4'b0100: v = a | b;
      4'b0101: v = ~a;
      4'b0110: v = {6'b0, ins[5:0]};
      default: wr = 1'b0;
    endcase
    if (wr) begin
      e.ill = 1'b0; e.rd = rd; e.val = v;
      sb_q.push_back(e);
    end else if (op > 4'b0110) begin
      e.ill = 1'b1; e.rd = '0; e.val = '0;
      sb_q.push_back(e);
    end
    wait_ready();
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (instr_ready !== 1'b0 || alu_a !== a || alu_b !== b ||
        alu_sel !== ((op >= 4'b0001 && op <= 4'b0101) ? op : 4'b0000)) begin
      errors++;
      $display("FAIL exec_phase op=%h: ready=%0b a=%h b=%h sel=%b, required ready=0 a=%h b=%h",
               op, instr_ready, alu_a, alu_b, alu_sel, a, b);
    end
    @(negedge clk);
    checks++;
    if (instr_ready !== 1'b0 || alu_sel !== 4'b0000 || alu_a !== 12'h000 || alu_b !== 12'h000) begin
      errors++;
      $display("FAIL wb_phase op=%h: ready=%0b a=%h b=%h sel=%b, required ready=0 a=b=0 sel=0",
               op, instr_ready, alu_a, alu_b, alu_sel);
    end
    if (wr) mdl[rd] = v;
    @(negedge clk);
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_return op=%h: ready=%0b, required 1", op, instr_ready);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      checks++;
      if (dbg_data !== mdl[i]) begin
        errors++;
        $display("FAIL regs_%s R%0d: dbg_data=%h, required %h", tag, i, dbg_data, mdl[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) mdl[i] = 12'h000;
    @(negedge clk);
    checks++;
    if (instr_ready !== 1'b1 || result_valid !== 1'b0 || illegal !== 1'b0 ||
        alu_sel !== 4'b0 || alu_a !== 12'h0 || alu_b !== 12'h0 ||
        result !== 12'h0 || result_rd !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%0b valid=%0b ill=%0b sel=%b a=%h b=%h res=%h rd=%0d, required ready=1 rest 0",
               instr_ready, result_valid, illegal, alu_sel, alu_a, alu_b, result, result_rd);
    end
    check_regs("reset");
  endtask

  task automatic test_ldi();
    issue(mk(4'b0110, 2'd1, 2'd3, 2'd3) | 12'h03F);
    issue(mk(4'b0110, 2'd2, 2'd0, 2'd0) | 12'h001);
    check_regs("ldi");
  endtask

  task automatic test_add();
    issue(mk(4'b0001, 2'd3, 2'd1, 2'd2));
    dbg_addr = 2'd3;
    #1;
    checks++;
    if (dbg_data !== 12'h040) begin
      errors++;
      $display("FAIL add_dbg: R3=%h, required 040", dbg_data);
    end
  endtask

  task automatic test_wrap();
    issue(mk(4'b0010, 2'd0, 2'd0, 2'd2));
    dbg_addr = 2'd0;
    #1;
    checks++;
    if (dbg_data !== 12'hFFF) begin
      errors++;
      $display("FAIL sub_wrap: R0=%h, required FFF", dbg_data);
    end
    issue(mk(4'b0001, 2'd0, 2'd0, 2'd2));
    #1;
    checks++;
    if (dbg_data !== 12'h000) begin
      errors++;
      $display("FAIL add_wrap: R0=%h, required 000", dbg_data);
    end
  endtask

  task automatic test_logic();
    issue(mk(4'b0101, 2'd1, 2'd1, 2'd2));
    issue(mk(4'b0011, 2'd0, 2'd1, 2'd3));
    issue(mk(4'b0100, 2'd2, 2'd1, 2'd3));
    check_regs("logic");
    checks++;
    if (mdl[1] !== 12'hFC0 || mdl[0] !== 12'h040 || mdl[2] !== 12'hFC0) begin
      errors++;
      $display("FAIL logic_model: R0=%h R1=%h R2=%h, required 040 FC0 FC0", mdl[0], mdl[1], mdl[2]);
    end
  endtask

  task automatic test_illegal_nop();
    int p0;
    p0 = pulses;
    issue(mk(4'b1010, 2'd1, 2'd2, 2'd3));
    issue(mk(4'b0000, 2'd2, 2'd1, 2'd1));
    checks++;
    if (pulses - p0 != 1) begin
      errors++;
      $display("FAIL illegal_nop_pulses: %0d pulses, required 1", pulses - p0);
    end
    check_regs("illegal");
  endtask

  task automatic test_back_to_back();
    int p0;
    wait_ready();
    instr = mk(4'b0001, 2'd3, 2'd1, 2'd2);
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) mdl[i] = 12'h000;
    @(negedge clk);
    checks++;
    if (instr_ready !== 1'b1 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: ready=%0b valid=%0b, required ready=1 valid=0", instr_ready, result_valid);
    end
    check_regs("abort");
    p0 = pulses;
    begin
      exp_t e;
      e.ill = 1'b0; e.rd = 2'd2; e.val = 12'h015;
      sb_q.push_back(e);
    end
    instr = mk(4'b0110, 2'd2, 2'd1, 2'd1) | 12'h015;
    instr_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 instr_valid = 1'b0;
    mdl[2] = 12'h015;
    repeat (4) @(negedge clk);
    checks++;
    if (pulses - p0 != 1) begin
      errors++;
      $display("FAIL held_valid_accepts: %0d pulses, required 1", pulses - p0);
    end
    check_regs("held");
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_add();
    test_wrap();
    test_logic();
    test_illegal_nop();
    test_back_to_back();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
